// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side handshake bundle for the hazard controller: decode/execute
// hazard inputs in, fetch/ID-EX enables and event counters out.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             id_terminate;
  logic             ex_mem_r;
  logic [4:0]       ex_reg_dest;
  logic             ex_branch_taken;
  logic             pc_en;
  logic             if_id_en;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             halted;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_terminate,
           ex_mem_r, ex_reg_dest, ex_branch_taken,
    output pc_en, if_id_en, if_id_flush, id_ex_bubble, halted,
           stall_count, flush_count
  );

  modport slave (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_terminate,
           ex_mem_r, ex_reg_dest, ex_branch_taken,
    input  pc_en, if_id_en, if_id_flush, id_ex_bubble, halted,
           stall_count, flush_count
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Load-use stall, taken-branch flush and terminate/drain/halt sequencing for
// the fetch and ID/EX stages, with saturating stall/flush event counters.
module pipe_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.master bus
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t           state;
  state_t           next_state;
  logic             active;
  logic [3:0]       dcnt;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;
  logic             lu;
  logic             stall_ev;
  logic             flush_ev;
  logic             drain_load;

  // Register 0 is hardwired, so a load targeting it can never create a hazard.
  assign lu = bus.ex_mem_r & (bus.ex_reg_dest != 5'd0) &
              ((bus.id_use_rs & (bus.id_rs == bus.ex_reg_dest)) |
               (bus.id_use_rt & (bus.id_rt == bus.ex_reg_dest)));

  // Outputs stay in the safe stalled pattern until the first edge after reset
  // release; `active` marks that edge.
  always_comb begin
    next_state       = state;
    bus.pc_en        = 1'b0;
    bus.if_id_en     = 1'b0;
    bus.if_id_flush  = 1'b0;
    bus.id_ex_bubble = 1'b1;
    bus.halted       = 1'b0;
    stall_ev         = 1'b0;
    flush_ev         = 1'b0;
    drain_load       = 1'b0;
    if (active) begin
      case (state)
        RUN: begin
          bus.pc_en        = 1'b1;
          bus.if_id_en     = 1'b1;
          bus.id_ex_bubble = 1'b0;
          if (bus.ex_branch_taken) begin
            bus.if_id_flush  = 1'b1;
            bus.id_ex_bubble = 1'b1;
            flush_ev         = 1'b1;
          end else if (lu) begin
            bus.pc_en        = 1'b0;
            bus.if_id_en     = 1'b0;
            bus.id_ex_bubble = 1'b1;
            stall_ev         = 1'b1;
          end else if (bus.id_terminate) begin
            bus.pc_en    = 1'b0;
            bus.if_id_en = 1'b0;
            drain_load   = 1'b1;
            next_state   = DRAIN;
          end
        end
        DRAIN: begin
          if (dcnt == 4'd1) next_state = HALTED;
        end
        HALTED: begin
          bus.halted = 1'b1;
        end
        default: next_state = RUN;
      endcase
    end
  end

  // Counters check for all-ones before incrementing so they pin at the maximum.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= RUN;
      active  <= 1'b0;
      dcnt    <= 4'd0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      active <= 1'b1;
      state  <= next_state;
      if (drain_load)
        dcnt <= 4'(DRAIN_CYCLES);
      else if (state == DRAIN)
        dcnt <= dcnt - 4'd1;
      if (stall_ev && (stall_q != '1))
        stall_q <= stall_q + CNT_W'(1);
      if (flush_ev && (flush_q != '1))
        flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign bus.stall_count = stall_q;
  assign bus.flush_count = flush_q;

endmodule
